// File: rtl/matrix_frame_dma.sv
`default_nettype none
// ============================================================================
// Module      : matrix_frame_dma
// Description : Copies one 8-word frame from source memory to a matrix video
//               sink, then issues a display-swap command word at address 8.
//               A transfer starts on a start pulse or on a periodic auto tick.
//               One trigger that arrives while a transfer is running is kept
//               as pending. A fetch that gets no mem_ack within TMO_CYC cycles
//               aborts the frame without committing it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle transfer request
//   base_addr[29:0]     word address of frame word 0, latched on acceptance
//   auto_en, period     periodic trigger enable and interval (0 = off)
//   mem_req/addr/ack/rdata   source read port (rdata valid with ack)
//   vid_address/data/we      video sink write port
//   busy, done, err     status: not idle, commit pulse, timeout pulse
//   frame_cnt[7:0]      committed-frame counter (wraps)
// ============================================================================
module matrix_frame_dma #(
    parameter int PERIOD_W = 16,
    parameter int TMO_CYC  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [29:0]         base_addr,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] period,
    output logic                mem_req,
    output logic [29:0]         mem_addr,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata,
    output logic [29:0]         vid_address,
    output logic [31:0]         vid_data,
    output logic                vid_we,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [7:0]          frame_cnt
);

    localparam int                WAIT_W    = $clog2(TMO_CYC + 1);
    localparam logic [WAIT_W-1:0] TMO_LIMIT = WAIT_W'(TMO_CYC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WRITE  = 3'd2,
        S_COMMIT = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t              state, next_state;
    logic [2:0]          idx;
    logic [29:0]         base;
    logic [31:0]         word;
    logic                got;        // word captured; this FETCH cycle is the post-ack cycle
    logic                pending;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [PERIOD_W-1:0] auto_cnt;

    logic auto_on, tick, trig;
    logic latch, inc_idx, capture;

    // ---------------- auto trigger ----------------
    assign auto_on = auto_en && (period != '0);
    assign tick    = auto_on && (auto_cnt == period - PERIOD_W'(1));
    assign trig    = start | tick;

    always_ff @(posedge clk) begin
        if (rst || !auto_on) begin
            auto_cnt <= '0;
        end else if (tick) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + PERIOD_W'(1);
        end
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        next_state  = state;
        latch       = 1'b0;
        inc_idx     = 1'b0;
        capture     = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        vid_we      = 1'b0;
        vid_address = '0;
        vid_data    = '0;
        done        = 1'b0;
        err         = 1'b0;
        busy        = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (trig) begin
                    next_state = S_FETCH;
                    latch      = 1'b1;
                end
            end
            S_FETCH: begin
                if (got) begin
                    // Request is already dropped; the captured word goes out next.
                    next_state = S_WRITE;
                end else if (wait_cnt == TMO_LIMIT) begin
                    err        = 1'b1;
                    next_state = S_FINISH;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = base + {27'b0, idx};
                    capture  = mem_ack;
                end
            end
            S_WRITE: begin
                vid_we      = 1'b1;
                vid_address = {27'b0, idx};
                vid_data    = word;
                if (idx == 3'd7) begin
                    next_state = S_COMMIT;
                end else begin
                    inc_idx    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_COMMIT: begin
                // Address 8 is the display-swap command.
                vid_we      = 1'b1;
                vid_address = 30'd8;
                done        = 1'b1;
                next_state  = S_FINISH;
            end
            S_FINISH: begin
                // A trigger landing in this very cycle is treated like a pending one.
                if (pending || trig) begin
                    latch      = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            base      <= '0;
            word      <= '0;
            got       <= 1'b0;
            pending   <= 1'b0;
            wait_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            state <= next_state;
            got   <= capture;

            if (latch) begin
                base <= base_addr;
                idx  <= '0;
            end else if (inc_idx) begin
                idx <= idx + 3'd1;
            end

            if (capture) begin
                word <= mem_rdata;
            end

            // Clears on every FETCH entry, counts while staying in FETCH.
            if (state == S_FETCH && next_state == S_FETCH) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (state == S_FINISH) begin
                pending <= 1'b0;
            end else if (state != S_IDLE && trig) begin
                pending <= 1'b1;
            end

            if (state == S_COMMIT) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_frame_dma
// Description : Directed self-checking bench for matrix_frame_dma.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_frame_dma;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst, start, auto_en;
    logic [29:0] base_addr;
    logic [15:0] period;
    logic        mem_req, mem_ack;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [29:0] vid_address;
    logic [31:0] vid_data;
    logic        vid_we, busy, done, err;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    matrix_frame_dma #(.PERIOD_W(16), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .auto_en(auto_en), .period(period),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .vid_address(vid_address), .vid_data(vid_data), .vid_we(vid_we),
        .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
    );

    // Source memory: word at address A holds 0xA0000000 + A; ack after lat request cycles.
    logic [7:0]  lat;
    logic [7:0]  req_cnt;
    logic        hold_en;
    logic [29:0] hold_addr;

    always @(posedge clk) req_cnt <= mem_req ? req_cnt + 8'd1 : 8'd0;

    assign mem_ack   = mem_req && (req_cnt == lat - 8'd1) && !(hold_en && mem_addr == hold_addr);
    assign mem_rdata = 32'hA000_0000 + {2'b00, mem_addr};

    int checks = 0;
    int errors = 0;

    // Activity log sampled on the falling edge.
    logic [29:0] wa[$];
    logic [31:0] wd[$];
    int done_n, err_n, busy_n, cyc, hold_cyc, err_cyc;

    initial cyc = 0;
    always @(negedge clk) begin
        cyc++;
        if (vid_we) begin
            wa.push_back(vid_address);
            wd.push_back(vid_data);
        end
        if (done) done_n++;
        if (err) begin
            err_n++;
            err_cyc = cyc;
        end
        if (busy) busy_n++;
        if (hold_en && mem_req && mem_addr == hold_addr && hold_cyc < 0) hold_cyc = cyc;
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_n = 0; err_n = 0; busy_n = 0; hold_cyc = -1; err_cyc = -1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b still after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic wait_write(input logic [29:0] a);
        int n = 0;
        @(negedge clk);
        while (!(vid_we && vid_address == a) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(vid_we && vid_address == a)) begin
            errors++;
            $display("FAIL wait_write: no write to addr %0d seen (vid_we=%0b addr=%0d)", a, vid_we, vid_address);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_req, vid_we, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000", {mem_req, vid_we, busy, done, err});
        end
        checks++;
        if (frame_cnt !== 8'd0 || mem_addr !== 30'd0 || vid_address !== 30'd0 || vid_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: fc=%0d maddr=%h vaddr=%h vdata=%h required all 0",
                     frame_cnt, mem_addr, vid_address, vid_data);
        end
        // Start coincident with the last reset cycle must be ignored.
        start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_frame(input logic [29:0] b, input logic [7:0] l, input logic [7:0] fc_exp);
        logic [29:0] a;
        base_addr = b;
        lat       = l;
        clear_log();
        pulse_start();
        wait_idle();
        checks++;
        if (busy_n != 8 * (int'(l) + 2) + 2) begin
            errors++;
            $display("FAIL frame_cycles: got %0d required %0d", busy_n, 8 * (int'(l) + 2) + 2);
        end
        checks++;
        if (wa.size() != 9) begin
            errors++;
            $display("FAIL frame_writes: got %0d writes required 9", wa.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                a = b + 30'(i);
                checks++;
                if (wa[i] !== 30'(i) || wd[i] !== 32'hA000_0000 + {2'b00, a}) begin
                    errors++;
                    $display("FAIL frame_word%0d: addr=%0d data=%h required addr=%0d data=%h",
                             i, wa[i], wd[i], i, 32'hA000_0000 + {2'b00, a});
                end
            end
            checks++;
            if (wa[8] !== 30'd8 || wd[8] !== 32'd0) begin
                errors++;
                $display("FAIL frame_commit: addr=%0d data=%h required addr=8 data=0", wa[8], wd[8]);
            end
        end
        checks++;
        if (done_n != 1 || frame_cnt !== fc_exp) begin
            errors++;
            $display("FAIL frame_done: done=%0d fc=%0d required done=1 fc=%0d", done_n, frame_cnt, fc_exp);
        end
    endtask

    task automatic test_back_to_back();
        base_addr = 30'h200;
        lat       = 8'd1;
        clear_log();
        pulse_start();
        wait_write(30'd3);
        pulse_start();
        wait_write(30'd5);
        pulse_start();
        wait_idle();
        checks++;
        if (busy_n != 52 || done_n != 2) begin
            errors++;
            $display("FAIL b2b_cycles: busy=%0d done=%0d required busy=52 done=2", busy_n, done_n);
        end
        checks++;
        if (wa.size() != 18 || frame_cnt !== 8'd5) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d fc=%0d required writes=18 fc=5", wa.size(), frame_cnt);
        end else begin
            checks++;
            if (wa[8] !== 30'd8 || wa[9] !== 30'd0 || wd[9] !== 32'hA000_0200) begin
                errors++;
                $display("FAIL b2b_order: w8=%0d w9=%0d d9=%h required 8 0 a0000200", wa[8], wa[9], wd[9]);
            end
        end
    endtask

    task automatic test_timeout();
        base_addr = 30'h300;
        lat       = 8'd1;
        hold_addr = 30'h304;
        hold_en   = 1'b1;
        clear_log();
        pulse_start();
        wait_idle();
        hold_en = 1'b0;
        checks++;
        if (err_n != 1 || err_cyc - hold_cyc != TMO) begin
            errors++;
            $display("FAIL tmo_err: pulses=%0d delay=%0d required 1 pulse delay=%0d", err_n, err_cyc - hold_cyc, TMO);
        end
        checks++;
        if (busy_n != 34) begin
            errors++;
            $display("FAIL tmo_cycles: got %0d required 34", busy_n);
        end
        checks++;
        if (wa.size() != 4 || done_n != 0 || frame_cnt !== 8'd5) begin
            errors++;
            $display("FAIL tmo_nocommit: writes=%0d done=%0d fc=%0d required 4 0 5", wa.size(), done_n, frame_cnt);
        end
    endtask

    task automatic test_auto();
        lat    = 8'd1;
        period = 16'd100;
        clear_log();
        @(posedge clk); #1 auto_en = 1'b1;
        repeat (99) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL auto_early: busy=%0b after 99 cycles required 0", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL auto_tick: busy=%0b after 100 cycles required 1", busy);
        end
        repeat (450) @(posedge clk);
        #1 auto_en = 1'b0;
        wait_idle();
        checks++;
        if (done_n != 5 || frame_cnt !== 8'd10) begin
            errors++;
            $display("FAIL auto_frames: done=%0d fc=%0d required 5 10", done_n, frame_cnt);
        end
        period = 16'd0;
        clear_log();
        @(posedge clk); #1 auto_en = 1'b1;
        repeat (300) @(posedge clk);
        #1 auto_en = 1'b0;
        checks++;
        if (busy_n != 0 || frame_cnt !== 8'd10) begin
            errors++;
            $display("FAIL auto_period0: busy cycles=%0d fc=%0d required 0 10", busy_n, frame_cnt);
        end
        period = 16'd100;
    endtask

    task automatic test_reset_mid();
        base_addr = 30'h400;
        lat       = 8'd1;
        pulse_start();
        wait_write(30'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mem_req, vid_we, busy, done, err} !== 5'b0 || vid_address !== 30'd0 || vid_data !== 32'd0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_out: ctrl=%b vaddr=%0d vdata=%h fc=%0d required all 0",
                     {mem_req, vid_we, busy, done, err}, vid_address, vid_data, frame_cnt);
        end
        rst = 1'b0;
        clear_log();
        repeat (5) @(negedge clk);
        checks++;
        if (wa.size() != 0 || busy_n != 0) begin
            errors++;
            $display("FAIL midrst_quiet: writes=%0d busy cycles=%0d required 0 0", wa.size(), busy_n);
        end
        test_frame(30'h400, 8'd1, 8'd1);
    endtask

    task automatic test_wrap();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        lat = 8'd1;
        for (int f = 0; f < 256; f++) begin
            pulse_start();
            wait_idle();
            if (f == 254) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: fc=%0d required 255", frame_cnt);
                end
            end
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_0: fc=%0d required 0", frame_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; auto_en = 1'b0; period = 16'd100;
        base_addr = 30'h100; lat = 8'd1; hold_en = 1'b0; hold_addr = '0;
        clear_log();
        test_reset();
        test_frame(30'h100, 8'd1, 8'd1);
        test_frame(30'h100, 8'd2, 8'd2);
        test_frame(30'h3FFF_FFFC, 8'd1, 8'd3);
        test_back_to_back();
        test_timeout();
        test_auto();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
